// File: rtl/arm_seq_ctrl_if.sv
// Sequencer <-> program memory / ALU datapath bundle.
// master = sequencer side, slave = memory + ALU + start-control side.
// Widths follow the sequencer's PC and register-select parameters.
interface arm_seq_ctrl_if #(
  parameter int PC_W  = 8,
  parameter int SEL_W = 3
);
  // start request
  logic             run;
  // program memory port
  logic             pm_en;
  logic [PC_W-1:0]  pm_addr;
  logic [15:0]      pm_rdata;
  // instruction / datapath control
  logic [15:0]      ir;
  logic [SEL_W-1:0] rd_sel;
  logic [SEL_W-1:0] rs_sel;
  logic             exec1;
  logic [15:0]      alu_d;
  // status
  logic             zflag;
  logic             busy;
  logic             halted;

  modport master (
    input  run, pm_rdata, alu_d,
    output pm_en, pm_addr, ir, rd_sel, rs_sel, exec1, zflag, busy, halted
  );

  modport slave (
    output run, pm_rdata, alu_d,
    input  pm_en, pm_addr, ir, rd_sel, rs_sel, exec1, zflag, busy, halted
  );
endinterface

// File: rtl/arm_seq_ctrl.sv
// Fetch/execute sequencer: fetches 16-bit words, holds them in ir, strobes exec1, resolves NOP/JMP/JZ/HALT.
// Latency: 4 cycles per instruction (FETCH, LOAD, EXEC0, EXEC1); first pm_en 1 cycle after run seen in IDLE.
// No backpressure: memory data is expected 1 cycle after pm_en, ALU result while exec1 is high.
module arm_seq_ctrl #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              SEL_W    = 3
) (
  input  logic          clk,
  input  logic          reset,
  arm_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_EXEC0 = 3'd3,
    S_EXEC1 = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  // Control-flow opcodes in ir[14:12] when ir[15] = 0; 100-111 fall through as NOP.
  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_JZ   = 3'b010;
  localparam logic [2:0] OP_HALT = 3'b011;

  state_t          state_q,  state_d;
  logic [PC_W-1:0] pc_q,     pc_d;
  logic [15:0]     ir_q,     ir_d;
  logic            zflag_q,  zflag_d;
  logic            pm_en_q,  pm_en_d;
  logic            exec1_q,  exec1_d;
  logic            busy_q,   busy_d;
  logic            halted_q, halted_d;

  logic            is_alu_op;
  logic [2:0]      ctl_op;
  logic [PC_W-1:0] jmp_target;

  assign is_alu_op  = ir_q[15];
  assign ctl_op     = ir_q[14:12];
  assign jmp_target = ir_q[PC_W-1:0];

  // Next-state logic; the status/strobe outputs are decoded from the next
  // state so they come straight out of flops aligned with the state they flag.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    zflag_d = zflag_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.run) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        // Memory word arrives this cycle; pc advances here so that a
        // jump resolved in EXEC1 simply overrides the incremented value.
        ir_d    = bus.pm_rdata;
        pc_d    = pc_q + PC_W'(1);
        state_d = S_EXEC0;
      end
      S_EXEC0: begin
        state_d = S_EXEC1;
      end
      S_EXEC1: begin
        state_d = S_FETCH;
        if (is_alu_op) begin
          zflag_d = (bus.alu_d == 16'h0000);
        end else begin
          // Control ops never touch zflag; JZ tests the value left by the
          // most recent ALU instruction.
          case (ctl_op)
            OP_NOP:  pc_d = pc_q;
            OP_JMP:  pc_d = jmp_target;
            OP_JZ:   if (zflag_q) pc_d = jmp_target;
            OP_HALT: state_d = S_HALT;
            default: pc_d = pc_q;
          endcase
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    pm_en_d  = (state_d == S_FETCH);
    exec1_d  = (state_d == S_EXEC1);
    busy_d   = (state_d == S_FETCH) || (state_d == S_LOAD) ||
               (state_d == S_EXEC0) || (state_d == S_EXEC1);
    halted_d = (state_d == S_HALT);
  end

  // All sequencer state and registered outputs; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      ir_q     <= 16'h0000;
      zflag_q  <= 1'b0;
      pm_en_q  <= 1'b0;
      exec1_q  <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      zflag_q  <= zflag_d;
      pm_en_q  <= pm_en_d;
      exec1_q  <= exec1_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  assign bus.pm_en   = pm_en_q;
  assign bus.pm_addr = pc_q;
  assign bus.ir      = ir_q;
  assign bus.rd_sel  = ir_q[2*SEL_W-1:SEL_W];
  assign bus.rs_sel  = ir_q[SEL_W-1:0];
  assign bus.exec1   = exec1_q;
  assign bus.zflag   = zflag_q;
  assign bus.busy    = busy_q;
  assign bus.halted  = halted_q;

endmodule

// File: tb/tb_arm_seq_ctrl.sv
// Bench for arm_seq_ctrl: synchronous program memory, small ALU with register file,
// and an instruction-level reference model (pc, zflag, registers) stepped per instruction.
module tb_arm_seq_ctrl;

  localparam int PC_W  = 8;
  localparam int SEL_W = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  arm_seq_ctrl_if #(.PC_W(PC_W), .SEL_W(SEL_W)) bus ();

  arm_seq_ctrl #(.PC_W(PC_W), .RESET_PC(8'h00), .SEL_W(SEL_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // environment: program memory and register file
  logic [15:0] mem [256];
  logic [15:0] env_rf [8];
  logic [15:0] rf_init [8];
  logic        rf_load = 1'b0;

  // reference model state
  logic [7:0]  ref_pc;
  logic        ref_z;
  logic [15:0] ref_rf [8];

  int dec_seen;

  function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return b;
      3'd3: return a - 16'd1;
      3'd4: return a & b;
      3'd5: return a | b;
      3'd6: return a ^ b;
      default: return a + 16'd1;
    endcase
  endfunction

  always @(posedge clk) if (bus.pm_en) bus.pm_rdata <= mem[bus.pm_addr];

  assign bus.alu_d = alu_f(bus.ir[14:12], env_rf[bus.rd_sel], env_rf[bus.rs_sel]);

  always @(posedge clk) begin
    if (rf_load) env_rf <= rf_init;
    else if (bus.exec1 && bus.ir[15]) env_rf[bus.rd_sel] <= bus.alu_d;
  end

  always @(negedge clk) if (bus.exec1 && bus.ir == 16'hB008) dec_seen++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 256; i++) mem[i] = 16'h3000;
  endtask

  task automatic set_rf(input logic [15:0] r0, input logic [15:0] r1, input logic [15:0] r2, input logic [15:0] r5);
    for (int i = 0; i < 8; i++) rf_init[i] = 16'(i);
    rf_init[0] = r0; rf_init[1] = r1; rf_init[2] = r2; rf_init[5] = r5;
    rf_load = 1'b1;
    @(negedge clk);
    rf_load = 1'b0;
    ref_rf = rf_init;
  endtask

  task automatic do_reset();
    bus.run = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy",   32'(bus.busy),    32'h0);
    chk("rst_pm_en",  32'(bus.pm_en),   32'h0);
    chk("rst_exec1",  32'(bus.exec1),   32'h0);
    chk("rst_halted", 32'(bus.halted),  32'h0);
    chk("rst_zflag",  32'(bus.zflag),   32'h0);
    chk("rst_pc",     32'(bus.pm_addr), 32'h0);
    chk("rst_ir",     32'(bus.ir),      32'h0);
    ref_pc = 8'h00;
    ref_z  = 1'b0;
  endtask

  // One instruction, entered at the negedge of its FETCH cycle; leaves at the
  // negedge after EXEC1. run is scrambled throughout: it must have no effect.
  task automatic step(output bit hit_halt);
    logic [15:0] w;
    logic [15:0] res;
    logic [7:0]  nxt;
    bit          h;
    w = mem[ref_pc];
    h = 1'b0;
    chk("fetch_en",   32'(bus.pm_en),   32'h1);
    chk("fetch_addr", 32'(bus.pm_addr), 32'(ref_pc));
    chk("fetch_busy", 32'(bus.busy),    32'h1);
    bus.run = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("load_en",    32'(bus.pm_en),   32'h0);
    chk("load_exec1", 32'(bus.exec1),   32'h0);
    bus.run = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("exec0_ir",   32'(bus.ir),      32'(w));
    chk("exec0_rd",   32'(bus.rd_sel),  32'(w[5:3]));
    chk("exec0_rs",   32'(bus.rs_sel),  32'(w[2:0]));
    chk("exec0_exec1",32'(bus.exec1),   32'h0);
    chk("exec0_pc",   32'(bus.pm_addr), 32'(8'(ref_pc + 8'd1)));
    bus.run = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("exec1_strobe", 32'(bus.exec1), 32'h1);
    chk("exec1_ir",     32'(bus.ir),    32'(w));
    bus.run = 1'($urandom_range(0, 1));
    nxt = ref_pc + 8'd1;
    if (w[15]) begin
      res = alu_f(w[14:12], ref_rf[w[5:3]], ref_rf[w[2:0]]);
      ref_rf[w[5:3]] = res;
      ref_z = (res == 16'h0000);
    end else begin
      if (w[14:12] == 3'd1) nxt = w[7:0];
      else if (w[14:12] == 3'd2 && ref_z) nxt = w[7:0];
      else if (w[14:12] == 3'd3) h = 1'b1;
    end
    ref_pc = nxt;
    @(negedge clk);
    chk("post_zflag",  32'(bus.zflag),   32'(ref_z));
    chk("post_pc",     32'(bus.pm_addr), 32'(ref_pc));
    chk("post_halted", 32'(bus.halted),  32'(h));
    chk("post_busy",   32'(bus.busy),    32'(!h));
    chk("post_exec1",  32'(bus.exec1),   32'h0);
    hit_halt = h;
  endtask

  // Start from IDLE with a run pulse, step up to max_instr instructions.
  task automatic run_prog(input int max_instr, input bit hold_run_after);
    bit h;
    h = 1'b0;
    bus.run = 1'b1;
    @(negedge clk);
    for (int i = 0; i < max_instr && !h; i++) step(h);
    if (h && hold_run_after) begin
      bus.run = 1'b1;
      repeat (4) begin
        @(negedge clk);
        chk("halt_hold",  32'(bus.halted),  32'h1);
        chk("halt_pm_en", 32'(bus.pm_en),   32'h0);
        chk("halt_pc",    32'(bus.pm_addr), 32'(ref_pc));
      end
    end
    bus.run = 1'b0;
  endtask

  initial begin
    logic [31:0] ex_bits, en_bits, h_bits;
    bus.run = 1'b0;
    fill_halt();
    repeat (2) @(negedge clk);
    do_reset();

    // reset while in EXEC0 aborts the instruction
    mem[0] = 16'hA005;
    set_rf(16'd7, 16'd0, 16'd0, 16'd9);
    bus.run = 1'b1;
    @(negedge clk);
    bus.run = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t1_async_busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("t1_no_exec1", 32'(bus.exec1),   32'h0);
      chk("t1_idle",     32'(bus.busy),    32'h0);
      chk("t1_pc",       32'(bus.pm_addr), 32'h0);
    end

    // exact cycle positions of pm_en / exec1 / halted after the run sample
    do_reset();
    fill_halt();
    mem[0] = 16'hA005;
    mem[1] = 16'h3000;
    set_rf(16'd0, 16'd0, 16'd0, 16'd5);
    bus.run = 1'b1;
    ex_bits = '0; en_bits = '0; h_bits = '0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      bus.run = 1'b0;
      ex_bits[c] = bus.exec1;
      en_bits[c] = bus.pm_en;
      h_bits[c]  = bus.halted;
    end
    chk("t2_exec1_cycles", ex_bits, 32'h110);
    chk("t2_pm_en_cycles", en_bits, 32'h022);
    chk("t2_halt_cycle",   h_bits,  32'h200);
    chk("t2_pc",           32'(bus.pm_addr), 32'h2);

    // countdown loop with JZ exit
    do_reset();
    fill_halt();
    mem[0] = 16'hA00A; mem[1] = 16'hB008; mem[2] = 16'h2004; mem[3] = 16'h1001; mem[4] = 16'h3000;
    set_rf(16'd0, 16'd0, 16'd3, 16'd0);
    dec_seen = 0;
    run_prog(20, 1'b0);
    chk("t3_dec_count", 32'(dec_seen),      32'd3);
    chk("t3_zflag",     32'(bus.zflag),     32'h1);
    chk("t3_halted",    32'(bus.halted),    32'h1);
    chk("t3_pc",        32'(bus.pm_addr),   32'h5);

    // jump to top of memory, NOP there wraps pc to 0
    do_reset();
    fill_halt();
    mem[0] = 16'h10FF; mem[8'hFF] = 16'h0000;
    set_rf(16'd1, 16'd1, 16'd1, 16'd1);
    run_prog(5, 1'b0);
    chk("t4_wrap_fetch", 32'(bus.pm_addr), 32'hFF);

    // JZ not taken when last ALU result nonzero
    do_reset();
    fill_halt();
    mem[0] = 16'hA00A; mem[1] = 16'h2005; mem[2] = 16'h3000; mem[5] = 16'h3000;
    set_rf(16'd0, 16'd0, 16'd1, 16'd0);
    run_prog(10, 1'b0);
    chk("t5_zflag", 32'(bus.zflag),   32'h0);
    chk("t5_pc",    32'(bus.pm_addr), 32'h3);

    // reserved op as NOP keeps zflag; run held high through HALT
    do_reset();
    fill_halt();
    mem[0] = 16'hA008; mem[1] = 16'h7000; mem[2] = 16'h3000;
    set_rf(16'd0, 16'd4, 16'd0, 16'd0);
    run_prog(10, 1'b1);
    chk("t6_zflag", 32'(bus.zflag),   32'h1);
    chk("t6_pc",    32'(bus.pm_addr), 32'h3);

    // random programs, some cut short by reset before halting
    for (int p = 0; p < 8; p++) begin
      do_reset();
      for (int a = 0; a < 256; a++) begin
        int k;
        logic [15:0] w;
        k = $urandom_range(0, 99);
        w = 16'($urandom);
        if (k < 50)      w[15] = 1'b1;
        else if (k < 65) w[15:12] = 4'h1;
        else if (k < 82) w[15:12] = 4'h2;
        else if (k < 86) w[15:12] = 4'h3;
        else if (k < 94) w[15:12] = 4'h0;
        else             w[15:12] = 4'(4 + $urandom_range(0, 3));
        mem[a] = w;
      end
      set_rf(16'($urandom_range(0, 3)), 16'($urandom_range(0, 3)),
             16'($urandom_range(0, 3)), 16'($urandom_range(0, 3)));
      run_prog(30, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
